// File: rtl/gb_lcd_emitter.sv
// gb_lcd_emitter: Game Boy LCD-bus transmitter that streams a 2-bit image from an external pixel source.
// Revision 1.0
`default_nettype none

module gb_lcd_emitter #(
  parameter int PX_DIV   = 4,
  parameter int H_ACTIVE = 160,
  parameter int V_ACTIVE = 144,
  parameter int H_TOTAL  = 456,
  parameter int V_TOTAL  = 154,
  parameter int H_SYNC   = 8,
  parameter int H_START  = 16
) (
  input  logic        CLK_16MHz,
  input  logic        reset,
  input  logic        enable,
  output logic [14:0] pix_addr,
  input  logic [1:0]  pix_data,
  output logic [1:0]  GB_DAT,
  output logic        GB_HSYNC,
  output logic        GB_VSYNC,
  output logic        GB_PX_CLK,
  output logic        frame_start
);

  localparam int DIV_W = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;
  localparam int H_W   = $clog2(H_TOTAL);
  localparam int V_W   = $clog2(V_TOTAL);

  localparam logic [DIV_W-1:0] C_DIV_LAST  = DIV_W'(PX_DIV - 1);
  localparam logic [DIV_W-1:0] C_DIV_HALF  = DIV_W'(PX_DIV / 2);
  localparam logic [DIV_W-1:0] C_DIV_ONE   = DIV_W'(1);
  localparam logic [H_W-1:0]   C_H_LAST    = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0]   C_H_ONE     = H_W'(1);
  localparam logic [H_W-1:0]   C_H_SYNC    = H_W'(H_SYNC);
  localparam logic [H_W-1:0]   C_H_ACT_LO  = H_W'(H_START);
  localparam logic [H_W-1:0]   C_H_ACT_HI  = H_W'(H_START + H_ACTIVE - 1);
  localparam logic [H_W-1:0]   C_FETCH_LO  = H_W'(H_START - 1);
  localparam logic [H_W-1:0]   C_FETCH_HI  = H_W'(H_START + H_ACTIVE - 2);
  localparam logic [V_W-1:0]   C_V_LAST    = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0]   C_V_ONE     = V_W'(1);
  localparam logic [V_W-1:0]   C_V_ACT_HI  = V_W'(V_ACTIVE);
  localparam logic [14:0]      C_H_ACT_A   = 15'(H_ACTIVE);
  localparam logic [14:0]      C_H_START_A = 15'(H_START);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [H_W-1:0]   h_q, h_d;
  logic [V_W-1:0]   v_q, v_d;
  logic [14:0]      pix_addr_q, pix_addr_d;
  logic [1:0]       dat_q, dat_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             pxclk_q, pxclk_d;
  logic             fs_q, fs_d;

  logic             running;
  logic             v_act;
  logic             act_d;
  logic             fetch_d;
  logic [14:0]      fetch_addr;

  // Next position in the frame; running=0 means the next cycle is idle.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    h_d     = '0;
    v_d     = '0;
    running = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_RUN;
          running = 1'b1;
        end
      end
      S_RUN: begin
        running = 1'b1;
        if (div_q != C_DIV_LAST) begin
          div_d = div_q + C_DIV_ONE;
          h_d   = h_q;
          v_d   = v_q;
        end else if (h_q != C_H_LAST) begin
          h_d = h_q + C_H_ONE;
          v_d = v_q;
        end else if (v_q != C_V_LAST) begin
          v_d = v_q + C_V_ONE;
        end else if (!enable) begin
          state_d = S_IDLE;
          running = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next position so registered values line up with the counters.
  always_comb begin
    v_act      = (v_d >= C_V_ONE) && (v_d <= C_V_ACT_HI);
    act_d      = running && v_act && (h_d >= C_H_ACT_LO) && (h_d <= C_H_ACT_HI);
    fetch_d    = running && v_act && (div_d == '0) && (h_d >= C_FETCH_LO) && (h_d <= C_FETCH_HI);
    fetch_addr = 15'(v_d - C_V_ONE) * C_H_ACT_A + 15'(h_d) + 15'd1 - C_H_START_A;

    hsync_d    = running && (h_d < C_H_SYNC);
    vsync_d    = running && (v_d == '0);
    pxclk_d    = act_d && (div_d < C_DIV_HALF);
    fs_d       = running && (v_d == '0) && (h_d == '0) && (div_d == '0);

    dat_d = '0;
    if (act_d) begin
      dat_d = (div_d == '0) ? pix_data : dat_q;
    end

    pix_addr_d = running ? pix_addr_q : '0;
    if (fetch_d) begin
      pix_addr_d = fetch_addr;
    end
  end

  always_ff @(posedge CLK_16MHz or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      pix_addr_q <= '0;
      dat_q      <= '0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      pxclk_q    <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      h_q        <= h_d;
      v_q        <= v_d;
      pix_addr_q <= pix_addr_d;
      dat_q      <= dat_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      pxclk_q    <= pxclk_d;
      fs_q       <= fs_d;
    end
  end

  assign pix_addr    = pix_addr_q;
  assign GB_DAT      = dat_q;
  assign GB_HSYNC    = hsync_q;
  assign GB_VSYNC    = vsync_q;
  assign GB_PX_CLK   = pxclk_q;
  assign frame_start = fs_q;

endmodule

`default_nettype wire

// File: tb/tb_gb_lcd_emitter.sv
// tb_gb_lcd_emitter: scoreboard bench for gb_lcd_emitter on a reduced frame geometry with PX_DIV=6.
`default_nettype none

module tb_gb_lcd_emitter;

  localparam int PX_DIV   = 6;
  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 4;
  localparam int H_TOTAL  = 20;
  localparam int V_TOTAL  = 7;
  localparam int H_SYNC   = 3;
  localparam int H_START  = 5;
  localparam int LINE     = H_TOTAL * PX_DIV;
  localparam int FRAME    = LINE * V_TOTAL;
  localparam int PIX      = H_ACTIVE * V_ACTIVE;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [14:0] pix_addr;
  logic [1:0]  pix_data = 2'b00;
  logic [1:0]  GB_DAT;
  logic        GB_HSYNC, GB_VSYNC, GB_PX_CLK, frame_start;

  gb_lcd_emitter #(
    .PX_DIV(PX_DIV), .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL), .H_SYNC(H_SYNC), .H_START(H_START)
  ) dut (
    .CLK_16MHz(clk), .reset(rst), .enable(enable), .pix_addr(pix_addr), .pix_data(pix_data),
    .GB_DAT(GB_DAT), .GB_HSYNC(GB_HSYNC), .GB_VSYNC(GB_VSYNC), .GB_PX_CLK(GB_PX_CLK),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Pixel source: data = low address bits, one clock of read latency.
  always @(posedge clk) pix_data <= pix_addr[1:0];

  int n_chk = 0;
  int n_err = 0;

  logic [1:0] exp_q[$];
  bit         exp_fs[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input bit cont);
    exp_fs.push_back(cont);
    for (int n = 0; n < PIX; n++) exp_q.push_back(2'(n % 4));
  endtask

  // Monitor state
  int  cyc = 0;
  bit  prev_px, prev_hs, prev_vs;
  int  px_hi, hs_hi, vs_hi;
  logic [1:0] dat_at_rise;
  bit  hs_rise_valid, fs_seen, frame_valid;
  int  last_hs_rise, last_fs;
  int  f_falls, f_hs, f_max;

  always @(negedge clk) begin
    logic [1:0] e;
    bit cont;
    cyc++;
    if (rst) begin
      prev_px = 0; prev_hs = 0; prev_vs = 0;
      px_hi = 0; hs_hi = 0; vs_hi = 0;
      hs_rise_valid = 0; fs_seen = 0; frame_valid = 0;
    end else begin
      if (int'(pix_addr) > f_max) f_max = int'(pix_addr);
      if (frame_start) begin
        if (exp_fs.size() == 0) begin
          check("fs_unexpected", 1, 0);
        end else begin
          cont = exp_fs.pop_front();
          check("fs_syncs", {GB_HSYNC, GB_VSYNC}, 2'b11);
          if (cont) begin
            if (fs_seen) check("fs_period", cyc - last_fs, FRAME);
          end else begin
            hs_rise_valid = 0;
          end
          if (frame_valid) begin
            check("frame_falls", f_falls, PIX);
            check("frame_hsyncs", f_hs, V_TOTAL);
            check("frame_max_addr", f_max, PIX - 1);
          end
        end
        frame_valid = 1; fs_seen = 1; last_fs = cyc;
        f_falls = 0; f_hs = 0; f_max = 0;
      end

      if (GB_PX_CLK && !prev_px) begin
        px_hi = 0;
        dat_at_rise = GB_DAT;
      end
      if (GB_PX_CLK) px_hi++;
      if (!GB_PX_CLK && prev_px) begin
        f_falls++;
        if (exp_q.size() == 0) begin
          check("fall_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("fall_dat", GB_DAT, e);
        end
        check("fall_syncs", {GB_HSYNC, GB_VSYNC}, 0);
        check("px_high_time", px_hi, PX_DIV / 2);
        check("dat_stable", GB_DAT, dat_at_rise);
        check("addr_range", int'(pix_addr < 15'(PIX)), 1);
      end

      if (GB_HSYNC && !prev_hs) begin
        if (hs_rise_valid) check("hs_period", cyc - last_hs_rise, LINE);
        hs_rise_valid = 1; last_hs_rise = cyc; f_hs++; hs_hi = 0;
      end
      if (GB_HSYNC) hs_hi++;
      if (!GB_HSYNC && prev_hs) check("hs_width", hs_hi, H_SYNC * PX_DIV);

      if (GB_VSYNC && !prev_vs) vs_hi = 0;
      if (GB_VSYNC) vs_hi++;
      if (!GB_VSYNC && prev_vs) begin
        check("vs_width", vs_hi, LINE);
        check("vs_fall_at_hs_rise", int'(GB_HSYNC && !prev_hs), 1);
      end

      prev_px = GB_PX_CLK; prev_hs = GB_HSYNC; prev_vs = GB_VSYNC;
    end
  end

  function automatic int outs_all();
    return int'({pix_addr, GB_DAT, GB_HSYNC, GB_VSYNC, GB_PX_CLK, frame_start});
  endfunction

  task automatic check_idle(input string name, input int cycles);
    int nz = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (outs_all() != 0) nz++;
    end
    check(name, nz, 0);
  endtask

  task automatic wait_fs();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (frame_start) begin
        ok = 1;
        break;
      end
    end
    check("fs_wait_timeout", int'(ok), 1);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", outs_all(), 0);
    rst = 1'b0;
    check_idle("idle_before_enable", 20);

    // Two back-to-back frames, enable dropped part-way through the second.
    @(posedge clk);
    #1;
    push_frame(1'b0);
    push_frame(1'b1);
    enable = 1'b1;
    repeat (FRAME + 3 * LINE) @(posedge clk);
    #1 enable = 1'b0;
    repeat (600) @(posedge clk);
    check_idle("idle_after_drop", 50);
    check("queue_drained_1", exp_q.size(), 0);
    check("fs_drained_1", exp_fs.size(), 0);

    // Restart, then reset mid-active-line (v=2, x=4).
    @(posedge clk);
    #1;
    push_frame(1'b0);
    enable = 1'b1;
    wait_fs();
    repeat (2 * LINE + (H_START + 4) * PX_DIV + 2) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("reset_async_outputs", outs_all(), 0);
    exp_q.delete();
    exp_fs.delete();
    repeat (3) @(posedge clk);
    push_frame(1'b0);
    #2 rst = 1'b0;
    wait_fs();
    repeat (100) @(posedge clk);
    #1 enable = 1'b0;
    repeat (FRAME) @(posedge clk);
    check_idle("idle_after_reset_frame", 30);
    check("final_falls", f_falls, PIX);
    check("final_hsyncs", f_hs, V_TOTAL);
    check("final_max_addr", f_max, PIX - 1);
    check("queue_drained_2", exp_q.size(), 0);
    check("fs_drained_2", exp_fs.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
